handshake_tx: RTL and testbench
===============================

HANDSHAKE_TX -- requirements
Module: handshake_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of the transferred word.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: maximum number of cycles spent in any wait state before abort; legal range 4..255.
REQ-003 clk  input  1: the single system clock; all state updates on its rising edge.
REQ-004 n_rst  input  1: asynchronous, active-low reset.
REQ-005 send  input  1: synchronous request to start one transfer; sampled only in IDLE.
REQ-006 tx_data  input  DATA_WIDTH: word to transfer; captured on the accepting edge.
REQ-007 ack_in  input  1: acknowledge from the asynchronous receiver; may change at any time relative to clk.
REQ-008 req_out  output  1: 4-phase request to the receiver, registered.
REQ-009 data_out  output  DATA_WIDTH: registered transfer word, stable whenever req_out=1.
REQ-010 busy  output  1: high in every state except IDLE.
REQ-011 done  output  1: one-cycle pulse on successful transfer completion.
REQ-012 err  output  1: high while in ERR state (timeout abort).

Function
REQ-013 The module SHALL pass ack_in through a two-flop synchronizer (reset value 0) and use only the second-stage output (ack_sync) in control logic.
REQ-014 States SHALL be IDLE, WAIT_HI, WAIT_LO, ERR; all outputs SHALL be registered or decoded from state only.
REQ-015 IDLE with send=1 at edge k: data_out<=tx_data, req_out<=1, state<=WAIT_HI, all effective after edge k.
REQ-016 IDLE with send=0: all registers hold; done SHALL be 0 in every cycle except REQ-018.
REQ-017 WAIT_HI with ack_sync=1: req_out<=0, state<=WAIT_LO.
REQ-018 WAIT_LO with ack_sync=0: state<=IDLE, done=1 for exactly the following cycle.
REQ-019 send asserted outside IDLE SHALL be ignored; tx_data changes outside IDLE SHALL NOT alter data_out.
REQ-020 data_out SHALL hold its last captured value until the next accepted send.
REQ-021 Latency: ack_in rising with setup met before edge m -> ack_sync=1 after edge m+1 -> req_out=0 after edge m+2.
REQ-022 A wait counter SHALL clear on every state entry and increment each cycle in WAIT_HI and WAIT_LO, saturating at TIMEOUT_CYCLES.
REQ-023 Counter reaching TIMEOUT_CYCLES-1 in either wait state without the exit condition: req_out<=0, state<=ERR, no done pulse.
REQ-024 ERR: err=1, req_out=0; exit to IDLE on the first edge with ack_sync=0; err SHALL drop on that edge.
REQ-025 Exit condition and timeout in the same cycle: exit condition SHALL win.
REQ-026 X on ack_in SHALL NOT propagate beyond the synchronizer into the state register in a 0/1-decaying flop model.

Reset
REQ-027 n_rst=0 SHALL immediately force state=IDLE, req_out=0, data_out=0, busy=0, done=0, err=0, counter=0, synchronizer flops=0, regardless of clk.
REQ-028 Reset asserted mid-transfer SHALL abort it with no done pulse; first send after release SHALL behave per REQ-015.
REQ-029 Release of n_rst SHALL occur away from the rising clk edge in all benches.

Verification
REQ-030 Power-on: n_rst=0 for 2 cycles, then release at negedge -> all outputs 0, busy=0.
REQ-031 Normal: tx_data=8'hA5, send pulse; receiver model raises ack_in 3 cycles after req_out=1, drops it 2 cycles after req_out=0 -> data_out=8'hA5 throughout req_out=1, req_out=0 two edges after ack_in rise, single done pulse, busy=0 after.
REQ-032 Ignored send: during WAIT_HI, send=1 with tx_data=8'h3C -> data_out stays 8'hA5, no second transfer.
REQ-033 Timeout: TIMEOUT_CYCLES=16, ack_in held 0 -> req_out=0 and err=1 16 cycles after req_out rose; err=0 next edge (ack_sync=0); no done.
REQ-034 Setup/hold violation: ack_in toggled 0.095 ns before and 0.05 ns after a rising edge -> ack_sync is 0 or 1 (never X), transfer completes with one done pulse.
REQ-035 Reset mid-operation: n_rst=0 while in WAIT_LO -> req_out=0, busy=0 immediately, no done pulse; subsequent send of 8'h5A completes normally.

Source files
------------

// File: rtl/handshake_tx.sv
`timescale 1ns/1ps
// handshake_tx
// ------------------------------------------------------------------
// Transmit side of a 4-phase request/acknowledge handshake towards an
// asynchronous receiver. A send request in IDLE captures tx_data and
// raises req_out. The module then waits for the synchronized
// acknowledge to rise, drops req_out, waits for the acknowledge to
// fall, and pulses done. If either wait state lasts too long the
// transfer is aborted into ERR, which is left once the acknowledge
// is seen low.
//
// Parameters
//   DATA_WIDTH      width of the transferred word
//   TIMEOUT_CYCLES  cycles allowed in one wait state (legal 4..255)
//
// Ports
//   clk       system clock, rising-edge active
//   n_rst     asynchronous active-low reset
//   send      start request, only looked at in IDLE
//   tx_data   word captured on the accepting edge
//   ack_in    acknowledge from the receiver (asynchronous to clk)
//   req_out   registered 4-phase request
//   data_out  registered transfer word, stable while req_out=1
//   busy      high in every state except IDLE
//   done      one-cycle pulse after a completed transfer
//   err       high while in the timeout-abort state
// ------------------------------------------------------------------
module handshake_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  send,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  ack_in,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // 8 bits cover the whole legal TIMEOUT_CYCLES range.
  localparam int                CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2,
    ERR     = 2'd3
  } state_t;

  state_t                  state_reg;
  logic                    ack_meta_reg;
  logic                    ack_sync_reg;
  logic [CNT_W-1:0]        wait_cnt_reg;
  logic                    req_reg;
  logic                    done_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    timeout_hit;

  // Two-flop synchronizer; only ack_sync_reg is used by the control
  // logic, so a metastable first stage never reaches the FSM.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ack_meta_reg <= 1'b0;
      ack_sync_reg <= 1'b0;
    end else begin
      ack_meta_reg <= ack_in;
      ack_sync_reg <= ack_meta_reg;
    end
  end

  // The counter has already been incremented TIMEOUT_CYCLES-1 times,
  // so this edge ends the TIMEOUT_CYCLES-th cycle in the wait state.
  assign timeout_hit = (wait_cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      req_reg      <= 1'b0;
      done_reg     <= 1'b0;
      data_reg     <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (send) begin
            data_reg     <= tx_data;
            req_reg      <= 1'b1;
            state_reg    <= WAIT_HI;
            wait_cnt_reg <= '0;
          end
        end

        WAIT_HI: begin
          // The exit condition is tested first so it wins over a
          // timeout occurring in the same cycle.
          if (ack_sync_reg) begin
            req_reg      <= 1'b0;
            state_reg    <= WAIT_LO;
            wait_cnt_reg <= '0;
          end else if (timeout_hit) begin
            req_reg      <= 1'b0;
            state_reg    <= ERR;
            wait_cnt_reg <= '0;
          end else if (wait_cnt_reg < CNT_MAX) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end

        WAIT_LO: begin
          if (!ack_sync_reg) begin
            state_reg    <= IDLE;
            done_reg     <= 1'b1;
            wait_cnt_reg <= '0;
          end else if (timeout_hit) begin
            req_reg      <= 1'b0;
            state_reg    <= ERR;
            wait_cnt_reg <= '0;
          end else if (wait_cnt_reg < CNT_MAX) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end

        ERR: begin
          req_reg <= 1'b0;
          if (!ack_sync_reg) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
          end
        end

        default: begin
          state_reg    <= IDLE;
          req_reg      <= 1'b0;
          wait_cnt_reg <= '0;
        end
      endcase
    end
  end

  assign req_out  = req_reg;
  assign data_out = data_reg;
  assign done     = done_reg;
  // busy and err are pure state decodes.
  assign busy     = (state_reg != IDLE);
  assign err      = (state_reg == ERR);

endmodule

// File: tb/tb_handshake_tx.sv
`timescale 1ns/1ps
module tb_handshake_tx;

  localparam int DW = 8;
  localparam int TO = 16;

  logic          tb_clk  = 1'b0;
  logic          n_rst   = 1'b0;
  logic          send    = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          ack_in  = 1'b0;
  logic          req_out;
  logic [DW-1:0] data_out;
  logic          busy;
  logic          done;
  logic          err;

  always #5 tb_clk = ~tb_clk;

  handshake_tx #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk      (tb_clk),
    .n_rst    (n_rst),
    .send     (send),
    .tx_data  (tx_data),
    .ack_in   (ack_in),
    .req_out  (req_out),
    .data_out (data_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a transfer is "active" from acceptance until
  // completion/abort; timing is tracked as edge numbers, and a wait
  // phase aborts when TO edges have elapsed since that phase began.
  bit            m_active, m_acked, m_abort, m_req, m_done;
  bit            m_s1, m_s2, s2_now;
  int            m_start, waited;
  logic [DW-1:0] m_data = '0;

  always @(posedge tb_clk) begin
    cyc++;
    if (!n_rst) begin
      m_active = 0; m_acked = 0; m_abort = 0; m_req = 0; m_done = 0;
      m_s1 = 0; m_s2 = 0; m_data = '0;
    end else begin
      s2_now = m_s2;
      waited = cyc - m_start;
      m_done = 0;
      if (!m_active) begin
        if (send) begin
          m_active = 1; m_acked = 0; m_abort = 0;
          m_data = tx_data; m_req = 1; m_start = cyc;
        end
      end else if (m_abort) begin
        if (!s2_now) begin m_active = 0; m_abort = 0; end
      end else if (!m_acked) begin
        if (s2_now) begin m_acked = 1; m_req = 0; m_start = cyc; end
        else if (waited >= TO) begin m_abort = 1; m_req = 0; end
      end else begin
        if (!s2_now) begin m_active = 0; m_done = 1; end
        else if (waited >= TO) m_abort = 1;
      end
      m_s2 = m_s1;
      m_s1 = ack_in;
    end
    #1;
    if (chk_en) begin
      check("cyc_req_out", req_out, m_req);
      check("cyc_data_out", data_out, m_data);
      check("cyc_busy", busy, m_active);
      check("cyc_done", done, m_done);
      check("cyc_err", err, m_abort);
    end
  end

  // Receiver: raise ack after hi_delay negedges, wait for req_out to
  // fall, drop ack two cycles later, then count done pulses.
  task automatic run_receiver(input int hi_delay, output int dones);
    int n;
    dones = 0;
    repeat (hi_delay) @(negedge tb_clk);
    ack_in = 1'b1;
    n = 0;
    while (req_out && n < 40) begin @(posedge tb_clk); #1; n++; end
    check("req_fall_bound", (n < 40), 1);
    repeat (2) @(negedge tb_clk);
    ack_in = 1'b0;
    repeat (8) begin @(posedge tb_clk); #1; if (done) dones++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, n;

    // Power-on reset
    #2;
    check("rst_req_out", req_out, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge tb_clk);
    @(negedge tb_clk);
    n_rst = 1'b1;
    chk_en = 1;
    #1;
    check("por_req_out", req_out, 0);
    check("por_data_out", data_out, 0);
    check("por_busy", busy, 0);
    check("por_done", done, 0);
    check("por_err", err, 0);

    // Normal transfer of A5 with exact edge latency
    @(negedge tb_clk); tx_data = 8'hA5; send = 1'b1;
    @(posedge tb_clk); #1;
    check("norm_req_rise", req_out, 1);
    check("norm_capture", data_out, 8'hA5);
    check("norm_busy", busy, 1);
    @(negedge tb_clk); send = 1'b0;
    repeat (2) @(negedge tb_clk);
    ack_in = 1'b1;
    @(posedge tb_clk); #1; check("norm_req_edge_m", req_out, 1);
    @(posedge tb_clk); #1; check("norm_req_edge_m1", req_out, 1);
    check("norm_data_stable", data_out, 8'hA5);
    @(posedge tb_clk); #1; check("norm_req_edge_m2", req_out, 0);
    repeat (2) @(negedge tb_clk);
    ack_in = 1'b0;
    dc = 0;
    repeat (8) begin @(posedge tb_clk); #1; if (done) dc++; end
    check("norm_done_count", dc, 1);
    check("norm_busy_after", busy, 0);
    check("norm_data_hold", data_out, 8'hA5);

    // Send during WAIT_HI is ignored
    @(negedge tb_clk); tx_data = 8'hA5; send = 1'b1;
    @(negedge tb_clk); send = 1'b0;
    @(negedge tb_clk); send = 1'b1; tx_data = 8'h3C;
    @(negedge tb_clk); send = 1'b0;
    check("ign_data", data_out, 8'hA5);
    run_receiver(1, dc);
    check("ign_done_count", dc, 1);
    check("ign_data_after", data_out, 8'hA5);
    check("ign_no_second_req", req_out, 0);
    check("ign_idle", busy, 0);

    // Timeout with ack held low
    @(negedge tb_clk); tx_data = 8'hC3; send = 1'b1;
    @(posedge tb_clk); #1;
    send = 1'b0;
    check("to_req_rise", req_out, 1);
    n = 0; dc = 0;
    while (!err && n < 40) begin @(posedge tb_clk); #1; n++; if (done) dc++; end
    check("to_cycles", n, 16);
    check("to_req_low", req_out, 0);
    check("to_err", err, 1);
    check("to_no_done", dc, 0);
    @(posedge tb_clk); #1;
    check("to_err_clear", err, 0);
    check("to_busy_clear", busy, 0);
    check("to_done_after", done, 0);

    // Ack edges very close to the clock edge
    @(negedge tb_clk); tx_data = 8'h96; send = 1'b1;
    @(posedge tb_clk); #1; send = 1'b0;
    @(posedge tb_clk);
    #9.905 ack_in = 1'b1;
    n = 0;
    while (req_out && n < 40) begin @(posedge tb_clk); #1; n++; end
    check("sh_req_fall", (n < 40), 1);
    check("sh_known", $isunknown({req_out, busy, done, err}), 0);
    repeat (2) @(posedge tb_clk);
    #0.05 ack_in = 1'b0;
    dc = 0;
    repeat (8) begin
      @(posedge tb_clk); #1;
      if (done) dc++;
      check("sh_known_loop", $isunknown({req_out, busy, done, err, data_out}), 0);
    end
    check("sh_done_count", dc, 1);
    check("sh_data", data_out, 8'h96);

    // Reset while in WAIT_LO
    @(negedge tb_clk); tx_data = 8'hE1; send = 1'b1;
    @(negedge tb_clk); send = 1'b0; ack_in = 1'b1;
    n = 0;
    while (req_out && n < 40) begin @(posedge tb_clk); #1; n++; end
    check("mid_reach_wait_lo", busy & ~req_out, 1);
    @(posedge tb_clk); #3;
    n_rst = 1'b0;
    #1;
    check("mid_req_out", req_out, 0);
    check("mid_busy", busy, 0);
    check("mid_data", data_out, 0);
    check("mid_err", err, 0);
    ack_in = 1'b0;
    dc = 0;
    repeat (2) begin @(posedge tb_clk); #1; if (done) dc++; end
    check("mid_no_done", dc, 0);
    @(negedge tb_clk); n_rst = 1'b1;
    @(negedge tb_clk); tx_data = 8'h5A; send = 1'b1;
    @(posedge tb_clk); #1;
    check("post_req_rise", req_out, 1);
    check("post_capture", data_out, 8'h5A);
    @(negedge tb_clk); send = 1'b0;
    run_receiver(3, dc);
    check("post_done_count", dc, 1);
    check("post_busy", busy, 0);
    check("post_data_hold", data_out, 8'h5A);

    repeat (3) @(posedge tb_clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
